// File: rtl/adder_stim_driver.sv
// Driver end of the adder interface: walks operand vectors, holds each for a
// settle window, then compares the DUT sum against an internal reference.
module adder_stim_driver #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_VECTORS   = 256,
  parameter int ERR_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH:0]     c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [WIDTH:0]     fail_c
);
  localparam int IDX_W = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       settle;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH:0]   expected;
  logic             launch, advance, check_en, mismatch;

  // The operand registers are the vector index itself: a is the low half.
  assign idx      = {b, a};
  assign idx_nxt  = idx + IDX_W'(1);
  assign expected = {1'b0, a} + {1'b0, b};
  assign mismatch = (c != expected);

  assign busy = (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    advance   = 1'b0;
    check_en  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_WAIT;
          launch    = 1'b1;
        end
      end
      S_WAIT: begin
        if (abort)                       state_nxt = S_IDLE;
        else if (settle == SETTLE_LAST)  state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // An abort landing on the check cycle discards that comparison.
        if (abort) state_nxt = S_IDLE;
        else begin
          check_en = 1'b1;
          if (idx == LAST_IDX) state_nxt = S_DONE;
          else begin
            state_nxt = S_WAIT;
            advance   = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a          <= '0;
      b          <= '0;
      settle     <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_c     <= '0;
    end else if (launch) begin
      a          <= '0;
      b          <= '0;
      settle     <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_c     <= '0;
    end else begin
      if (state == S_WAIT && !abort) settle <= settle + 4'd1;
      if (check_en && mismatch) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= a;
          fail_b     <= b;
          fail_c     <= c;
        end
      end
      if (advance) begin
        a      <= idx_nxt[WIDTH-1:0];
        b      <= idx_nxt[IDX_W-1:WIDTH];
        settle <= '0;
      end
    end
  end
endmodule

// File: tb/tb_adder_stim_driver.sv
// Scoreboard bench: two driver instances (default and a short saturating
// config) against a behavioural adder with selectable faults.
module tb_adder_stim_driver;
  typedef struct {
    int         busy_len;   // -1: not checked
    logic       done, pass;
    int         err;
    logic       fv;
    logic [3:0] fa, fb;
    logic [4:0] fc;
    logic [3:0] a, b;
  } exp_t;

  logic clk = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---- instance 0: defaults ----
  logic        rst0 = 1, start0 = 0, abort0 = 0;
  logic [3:0]  a0, b0, fa0, fb0;
  logic [4:0]  c0, fc0;
  logic        busy0, done0, pass0, fv0;
  logic [15:0] err0;
  int          mode0 = 0;   // 0 good, 1 c[4] stuck-at-0, 2 constant 0

  // ---- instance 1: short run, 2-bit error counter ----
  logic        rst1 = 1, start1 = 0, abort1 = 0;
  logic [3:0]  a1, b1, fa1, fb1;
  logic [4:0]  c1, fc1;
  logic        busy1, done1, pass1, fv1;
  logic [1:0]  err1;
  int          mode1 = 0;   // 0 good, 1 constant 0

  exp_t sb0[$];
  exp_t sb1[$];
  int   vq1[$];

  always_comb begin
    c0 = {1'b0, a0} + {1'b0, b0};
    if (mode0 == 1) c0 = c0 & 5'b01111;
    else if (mode0 == 2) c0 = '0;
    c1 = {1'b0, a1} + {1'b0, b1};
    if (mode1 == 1) c1 = '0;
  end

  adder_stim_driver dut0 (
    .clk(clk), .rst(rst0), .start(start0), .abort(abort0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_c(fc0)
  );

  adder_stim_driver #(.WIDTH(4), .SETTLE_CYCLES(3), .NUM_VECTORS(6), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .abort(abort1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_c(fc1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_rec(input string tag, input exp_t e, input int blen,
                           input logic done, input logic pass, input int err,
                           input logic fv, input logic [3:0] fa, input logic [3:0] fb,
                           input logic [4:0] fc, input logic [3:0] a, input logic [3:0] b);
    if (e.busy_len >= 0) chk({tag, ".busy_len"}, blen, e.busy_len);
    chk({tag, ".done"}, int'(done), int'(e.done));
    chk({tag, ".pass"}, int'(pass), int'(e.pass));
    chk({tag, ".err_count"}, err, e.err);
    chk({tag, ".fail_valid"}, int'(fv), int'(e.fv));
    chk({tag, ".fail_a"}, int'(fa), int'(e.fa));
    chk({tag, ".fail_b"}, int'(fb), int'(e.fb));
    chk({tag, ".fail_c"}, int'(fc), int'(e.fc));
    chk({tag, ".a"}, int'(a), int'(e.a));
    chk({tag, ".b"}, int'(b), int'(e.b));
  endtask

  function automatic exp_t mk(input int bl, input logic d, input logic p, input int e,
                              input logic fv, input int fa, input int fb, input int fc,
                              input int a, input int b);
    exp_t r;
    r.busy_len = bl; r.done = d; r.pass = p; r.err = e; r.fv = fv;
    r.fa = 4'(fa); r.fb = 4'(fb); r.fc = 5'(fc); r.a = 4'(a); r.b = 4'(b);
    return r;
  endfunction

  // Result monitor, instance 0: a run ends whenever busy falls.
  initial begin
    int blen = 0;
    logic pb = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy0) blen++;
      else if (pb) begin
        if (sb0.size() == 0) chk("dut0.unexpected_end", 1, 0);
        else begin
          e = sb0.pop_front();
          check_rec("dut0", e, blen, done0, pass0, int'(err0), fv0, fa0, fb0, fc0, a0, b0);
        end
        blen = 0;
      end
      pb = busy0;
    end
  end

  // Result and vector-sequence monitor, instance 1.
  initial begin
    int blen = 0, hold = 0, v;
    logic pb = 0;
    logic [3:0] pa = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy1) begin
        blen++;
        if (!pb || a1 != pa) begin
          if (pb) chk("dut1.hold_len", hold, 4);
          hold = 0;
          if (vq1.size() == 0) chk("dut1.unexpected_vector", 1, 0);
          else begin
            v = vq1.pop_front();
            chk("dut1.vec_a", int'(a1), v);
            chk("dut1.vec_b", int'(b1), 0);
          end
        end
        hold++;
        pa = a1;
      end else if (pb) begin
        chk("dut1.hold_len", hold, 4);
        if (sb1.size() == 0) chk("dut1.unexpected_end", 1, 0);
        else begin
          e = sb1.pop_front();
          check_rec("dut1", e, blen, done1, pass1, int'(err1), fv1, fa1, fb1, fc1, a1, b1);
        end
        blen = 0;
      end
      pb = busy1;
    end
  end

  task automatic pulse_start0();
    @(negedge clk); start0 = 1;
    @(negedge clk); start0 = 0;
  endtask

  task automatic pulse_start1();
    @(negedge clk); start1 = 1;
    @(negedge clk); start1 = 0;
  endtask

  task automatic wait_idle0(input int lim);
    int n = 0;
    while (busy0 && n < lim) begin @(negedge clk); n++; end
    chk("dut0.run_timeout", int'(busy0), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle1(input int lim);
    int n = 0;
    while (busy1 && n < lim) begin @(negedge clk); n++; end
    chk("dut1.run_timeout", int'(busy1), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.a", int'(a0), 0);
    chk("rst.b", int'(b0), 0);
    chk("rst.busy", int'(busy0), 0);
    chk("rst.done", int'(done0), 0);
    chk("rst.pass", int'(pass0), 0);
    chk("rst.err_count", int'(err0), 0);
    chk("rst.fail_valid", int'(fv0), 0);
    rst0 = 0; rst1 = 0;
    @(negedge clk);

    // Good adder: 256 vectors x 3 cycles, ends on 15+15=30.
    mode0 = 0;
    sb0.push_back(mk(768, 1, 1, 0, 0, 0, 0, 0, 15, 15));
    pulse_start0();
    wait_idle0(2000);
    chk("done_holds", int'(done0), 1);

    // c[4] stuck low: 120 pairs with a+b>=16; first in index order is a=15,b=1.
    mode0 = 1;
    sb0.push_back(mk(768, 1, 0, 120, 1, 15, 1, 0, 15, 15));
    pulse_start0();
    wait_idle0(2000);

    // Constant-0 DUT, abort sampled 10 cycles after start: vectors 0..2 checked
    // (1 and 2 fail), vector 3 is on the bus when the run stops.
    mode0 = 2;
    sb0.push_back(mk(10, 0, 0, 2, 1, 1, 0, 0, 3, 0));
    pulse_start0();
    repeat (9) @(negedge clk);
    abort0 = 1;
    @(negedge clk);
    abort0 = 0;
    wait_idle0(20);
    chk("abort.busy", int'(busy0), 0);
    chk("abort.done", int'(done0), 0);
    chk("abort.err_kept", int'(err0), 2);

    // Restart after abort begins from vector 0 with cleared status.
    mode0 = 0;
    sb0.push_back(mk(768, 1, 1, 0, 0, 0, 0, 0, 15, 15));
    pulse_start0();
    chk("restart.a", int'(a0), 0);
    chk("restart.b", int'(b0), 0);
    chk("restart.err_count", int'(err0), 0);
    chk("restart.fail_valid", int'(fv0), 0);
    wait_idle0(2000);

    // Reset together with start mid-run: everything returns to zero.
    mode0 = 2;
    pulse_start0();
    repeat (50) @(negedge clk);
    sb0.push_back(mk(-1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst0 = 1; start0 = 1;
    @(negedge clk);
    rst0 = 0; start0 = 0;
    chk("rst_mid.busy", int'(busy0), 0);
    repeat (3) @(negedge clk);
    mode0 = 0;
    sb0.push_back(mk(768, 1, 1, 0, 0, 0, 0, 0, 15, 15));
    pulse_start0();
    wait_idle0(2000);

    // Instance 1: 6 vectors x 4 cycles = 24; a repeated start is ignored.
    mode1 = 0;
    for (int i = 0; i < 6; i++) vq1.push_back(i);
    sb1.push_back(mk(24, 1, 1, 0, 0, 0, 0, 0, 5, 0));
    pulse_start1();
    repeat (6) @(negedge clk);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    wait_idle1(100);

    // Constant 0: vectors 1..5 mismatch, 2-bit counter saturates at 3.
    mode1 = 1;
    for (int i = 0; i < 6; i++) vq1.push_back(i);
    sb1.push_back(mk(24, 1, 0, 3, 1, 1, 0, 0, 5, 0));
    pulse_start1();
    wait_idle1(100);

    chk("sb0_leftover", sb0.size(), 0);
    chk("sb1_leftover", sb1.size(), 0);
    chk("vq1_leftover", vq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
